posit_dot_accum_ctrl_es3: RTL and testbench

//  Sequences one dot-product accumulation over a shared external product-sum adder.

---
 rtl/posit_dot_accum_ctrl_es3.sv | 143 ++++++++++++++
 tb/tb_posit_dot_accum_ctrl_es3.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/posit_dot_accum_ctrl_es3.sv
// Dot-product accumulation sequencer driving a shared external product-sum adder.
// Optional feature macro: POSIT_ACC_STICKY_INF_EN (a sticky inf flag bypasses the adder).
// Flat field layout, MSB first:
//   value_product = {sgn, inf, zero, scale[PSCALE_W-1:0], fraction[ABITS-1:0]}
//   value         = {sgn, inf, zero, scale[8:0], fraction[FBITS-1:0]}
module posit_dot_accum_ctrl_es3 #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ABITS    = 24,
  parameter int unsigned FBITS    = 12,
  parameter int unsigned PSCALE_W = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3+PSCALE_W+ABITS-1:0]  in_term,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [3+PSCALE_W+ABITS-1:0]  add_a,
  output logic [3+PSCALE_W+ABITS-1:0]  add_b,
  output logic                         add_start,
  input  logic [3+PSCALE_W+ABITS-1:0]  add_sum,
  input  logic                         add_done,
  output logic [3+9+FBITS-1:0]         out_result,
  output logic [CNT_W-1:0]             out_count,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned VP_W  = 3 + PSCALE_W + ABITS;
  localparam int unsigned SC_LO = ABITS;
  localparam int unsigned ZB    = ABITS + PSCALE_W;
  localparam int unsigned IB    = ZB + 1;
  localparam int unsigned SB    = ZB + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [VP_W-1:0] ACC_ZERO = VP_W'(1) << ZB;

  logic [1:0]       state_q, state_d;
  logic [VP_W-1:0]  acc_q, acc_d;
  logic [VP_W-1:0]  term_q, term_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             sticky_q, sticky_d;
  logic             in_ready_q, add_start_q, out_valid_q;
  logic             accept_c, inf_skip_c, need_add_c;

  assign accept_c = (state_q == S_IDLE) && in_ready_q && in_valid;

`ifdef POSIT_ACC_STICKY_INF_EN
  assign inf_skip_c = sticky_q | in_term[IB];
`else
  assign inf_skip_c = 1'b0;
`endif

  // An add is only needed for a non-zero, non-inf term joining a loaded accumulator
  assign need_add_c = !inf_skip_c && !in_term[ZB] && !first_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    term_d   = term_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    last_d   = last_q;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          term_d = in_term;
          last_d = in_last;
          cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (inf_skip_c) begin
            sticky_d = 1'b1;
          end else if (!in_term[ZB] && first_q) begin
            acc_d   = in_term;
            first_d = 1'b0;
          end
          if (need_add_c)   state_d = S_ISSUE;
          else if (in_last) state_d = S_DONE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (add_done) begin
          acc_d   = add_sum;
          state_d = last_q ? S_DONE : S_IDLE;
        end
      end
      default: begin
        if (out_ready) begin
          acc_d    = ACC_ZERO;
          first_d  = 1'b1;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= ACC_ZERO;
      term_q      <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      add_start_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      term_q      <= term_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      last_q      <= last_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= (state_d == S_IDLE);
      add_start_q <= (state_d == S_ISSUE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign add_start = add_start_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;
  assign add_a     = acc_q;
  assign add_b     = term_q;

  // Narrow the accumulator; sticky inf overrides the inf/zero flags
  assign out_result = {acc_q[SB], acc_q[IB] | sticky_q, acc_q[ZB] & ~sticky_q,
                       acc_q[SC_LO +: 9], acc_q[ABITS-1 -: FBITS]};

endmodule

// File: tb/tb_posit_dot_accum_ctrl_es3.sv
// Bench for posit_dot_accum_ctrl_es3: directed and randomized accumulations
// checked against a queue-based reference sum with a latency-4 a+b adder model.
module tb_posit_dot_accum_ctrl_es3;
  localparam int unsigned CNT_W = 16, ABITS = 24, FBITS = 12, PSCALE_W = 11;
  localparam int unsigned VP_W = 3 + PSCALE_W + ABITS, V_W = 12 + FBITS;
  localparam int unsigned ZB = ABITS + PSCALE_W, IB = ZB + 1, SB = ZB + 2;
  typedef logic [VP_W-1:0] vp_t;
  typedef logic [V_W-1:0]  v_t;

  logic clk, reset, in_valid, in_last, in_ready, add_start, add_done, out_valid, out_ready;
  vp_t in_term, add_a, add_b, add_sum;
  v_t out_result;
  logic [CNT_W-1:0] out_count;

  int total = 0, passed = 0, n_start = 0, pend = 0;
  logic chk_busy = 1'b0;
  vp_t pa, pb;

  posit_dot_accum_ctrl_es3 #(.CNT_W(CNT_W), .ABITS(ABITS), .FBITS(FBITS), .PSCALE_W(PSCALE_W)) dut (
    .clk(clk), .reset(reset), .in_term(in_term), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_sum(add_sum), .add_done(add_done), .out_result(out_result), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: captures operands on add_start, returns a+b four cycles later
  initial begin add_done = 1'b0; add_sum = '0; end
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin add_done <= 1'b1; add_sum <= pa + pb; end
    end
    if (add_start && pend == 0) begin pend <= 4; pa <= add_a; pb <= add_b; end
    if (add_start) n_start <= n_start + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) if (chk_busy && pend != 0) check("in_ready_during_wait", 64'(in_ready), 64'd0);

  function automatic vp_t mk(input logic s, input logic i, input logic z, input int sc, input int fr);
    return {s, i, z, PSCALE_W'(sc), ABITS'(fr)};
  endfunction

  function automatic v_t narrow(input vp_t a);
    logic [8:0] sc;
    logic [FBITS-1:0] f;
    sc = a[ABITS +: 9];
    f  = a[ABITS-1 -: FBITS];
    return {a[SB], a[IB], a[ZB], sc, f};
  endfunction

  // Reference: skip zero terms, load the first non-zero term, add each later one
  function automatic vp_t ref_sum(input vp_t q[$], output int adds);
    vp_t acc;
    bit first;
    acc = vp_t'(1) << ZB; first = 1; adds = 0;
    foreach (q[k]) begin
      if (q[k][ZB]) continue;
      if (first) begin acc = q[k]; first = 0; end
      else begin acc = acc + q[k]; adds++; end
    end
    return acc;
  endfunction

  function automatic vp_t rnd_term(input int zero_pct);
    vp_t r;
    r = vp_t'({$urandom(), $urandom()});
    r[IB] = 1'b0;
    r[ZB] = ($urandom_range(0, 99) < zero_pct);
    return r;
  endfunction

  task automatic send(input vp_t t, input logic last);
    int i;
    @(negedge clk);
    in_term = t; in_last = last; in_valid = 1'b1;
    i = 0;
    while (!in_ready && i < 200) begin @(negedge clk); i++; end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_acc(input string tag, input int cnt, input v_t exp_res, input int exp_adds, input int base);
    int i;
    i = 0;
    while (!out_valid && i < 400) begin @(negedge clk); i++; end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(exp_res));
    check({tag, "_count"}, 64'(out_count), 64'(cnt));
    check({tag, "_adds"}, 64'(n_start - base), 64'(exp_adds));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_acc(input string tag, input vp_t q[$]);
    int base, adds;
    vp_t exp_acc;
    base = n_start;
    foreach (q[k]) send(q[k], k == q.size() - 1);
    exp_acc = ref_sum(q, adds);
    finish_acc(tag, q.size(), narrow(exp_acc), adds, base);
  endtask

  initial begin
    vp_t q[$];
    vp_t t;
    v_t hold_exp;
    int base, i, n, adds;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_term = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_add_start", 64'(add_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_result", 64'(out_result), 64'(v_t'(1) << (9 + FBITS)));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single last term: no add, out_valid one cycle after acceptance
    base = n_start;
    t = mk(1'b1, 1'b0, 1'b0, 5, 1 << (ABITS - 1));
    send(t, 1'b1);
    check("single_latency", 64'(out_valid), 64'd1);
    check("single_sgn", 64'(out_result[V_W-1]), 64'd1);
    check("single_scale", 64'(out_result[FBITS +: 9]), 64'd5);
    finish_acc("single", 1, narrow(t), 0, base);

    // Three non-zero terms: two adds, in_ready low while each add is pending
    chk_busy = 1'b1;
    q = {rnd_term(0), rnd_term(0), rnd_term(0)};
    base = n_start;
    send(q[0], 1'b0); send(q[1], 1'b0); send(q[2], 1'b1);
    i = 0;
    while (!add_done && i < 100) begin @(negedge clk); i++; end
    check("add_done_seen", 64'(add_done), 64'd1);
    @(posedge clk); #1;
    check("add_latency", 64'(out_valid), 64'd1);
    finish_acc("three", 3, narrow(ref_sum(q, adds)), 2, base);

    run_acc("zeros", {mk(0, 0, 1, 0, 0), mk(0, 0, 1, 0, 0), mk(0, 0, 1, 0, 0)});
    chk_busy = 1'b0;

    // DONE held for 10 cycles without out_ready
    t = rnd_term(0);
    hold_exp = narrow(t);
    send(t, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_result", 64'(out_result), 64'(hold_exp));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    finish_acc("hold", 1, hold_exp, 0, n_start);
    run_acc("after_hold", {rnd_term(0)});

    // Reset while an add is pending, then a stray add_done arrives
    send(rnd_term(0), 1'b0); send(rnd_term(0), 1'b1);
    i = 0;
    while (pend == 0 && i < 50) begin @(negedge clk); i++; end
    check("wait_entered", 64'(pend != 0), 64'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    i = 0;
    while (!add_done && i < 50) begin @(negedge clk); i++; end
    check("stray_done_seen", 64'(add_done), 64'd1);
    @(negedge clk); @(negedge clk);
    check("stray_out_valid", 64'(out_valid), 64'd0);
    check("stray_in_ready", 64'(in_ready), 64'd1);
    check("stray_acc_zero", 64'(out_result), 64'(v_t'(1) << (9 + FBITS)));
    check("stray_count", 64'(out_count), 64'd0);
    run_acc("post_abort", {rnd_term(0)});

    // Randomized accumulations with a mix of zero terms
    for (int r = 0; r < 12; r++) begin
      q = {};
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) q.push_back(rnd_term(25));
      run_acc("random", q);
    end

`ifdef POSIT_ACC_STICKY_INF_EN
    q = {rnd_term(0), rnd_term(0), mk(0, 1, 0, 3, 0), rnd_term(0)};
    base = n_start;
    foreach (q[k]) send(q[k], k == 3);
    i = 0;
    while (!out_valid && i < 400) begin @(negedge clk); i++; end
    check("sticky_valid", 64'(out_valid), 64'd1);
    check("sticky_inf", 64'(out_result[V_W-2]), 64'd1);
    check("sticky_zero", 64'(out_result[V_W-3]), 64'd0);
    check("sticky_count", 64'(out_count), 64'd4);
    check("sticky_adds", 64'(n_start - base), 64'd1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    run_acc("after_sticky", {rnd_term(0), rnd_term(0)});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
